md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the next-generation MIPS core.
- Supports mult, multu, div, divu, mthi, mtlo. mfhi/mflo read the `hi`/`lo` outputs.
- Parametrised in operand width and per-operation latency.
- Exposes a `busy` flag so the pipeline controller can stall dependent md instructions.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_LAT, 5: cycles `busy` stays high after a mult/multu start; must be >= 1.
- DIV_LAT, 10: cycles `busy` stays high after a div/divu start; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle strobe that launches the operation given by `op`.
- op  input  2  operation: 0 = mult, 1 = multu, 2 = div, 3 = divu.
- a  input  WIDTH  rs operand; the dividend for div/divu.
- b  input  WIDTH  rt operand; the divisor for div/divu.
- wr_hi  input  1  mthi strobe.
- wr_lo  input  1  mtlo strobe.
- wdata  input  WIDTH  data written by mthi/mtlo.
- busy  output  1  high while an operation is in flight.
- hi  output  WIDTH  HI register; high product, or remainder.
- lo  output  WIDTH  LO register; low product, or quotient.

Behaviour:
- Reset:
  - hi = 0, lo = 0, busy = 0.
  - The internal counter and pending-result registers are cleared.
  - Reset during an operation aborts it; no commit occurs.
- Start acceptance: a start is accepted at edge T only if busy = 0 and reset = 0.
  - At edge T the unit computes the full result from `a`, `b`, `op`.
  - The result is captured into pending_hi and pending_lo.
  - The counter is loaded with LAT, which is MULT_LAT for op 0/1 and DIV_LAT for op 2/3.
- busy = (counter != 0). It is a registered output.
  - busy is high from cycle T+1 through cycle T+LAT inclusive.
- Counter: decrements by 1 every edge while non-zero.
- Commit:
  - On the edge where the counter goes 1 to 0, pending_hi and pending_lo are written to hi and lo.
  - The committed values are visible in the same cycle busy falls, which is cycle T+LAT+1.
  - hi and lo hold their previous values throughout the busy window.
- start while busy = 1 is ignored. Operands are not latched and the counter is unchanged.
- wr_hi / wr_lo:
  - When busy = 0 and start = 0, `wdata` is written to hi (or lo) at the edge.
  - wr_hi and wr_lo together write both registers.
  - Ignored while busy = 1.
  - If start = 1 in the same cycle, the start wins and the write is dropped.
- Arithmetic:
  - mult: signed WIDTH x WIDTH gives a 2·WIDTH product; hi gets the upper half, lo the lower half.
  - multu: as mult, but unsigned.
  - div: signed. Quotient truncates toward zero; remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - divu: unsigned. lo = quotient, hi = remainder.
  - Signed overflow (div of the most-negative value by -1): lo = most-negative value, hi = 0.
- Divide by zero (b = 0, op 2/3):
  - busy behaves normally for DIV_LAT cycles.
  - At commit, hi and lo remain unchanged.
- Back-to-back operation: a new start is accepted in the first cycle busy = 0, i.e. T+LAT+1. It sees the just-committed hi/lo.
- A start in the same cycle as reset is discarded.

Test Plan:
- mult, WIDTH = 32, MULT_LAT = 5: a = 0xFFFFFFFE (-2), b = 0x00000003 at T.
  - busy is high in T+1..T+5.
  - At T+6: hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, busy = 0.
- multu with the same operands.
  - Commit gives hi = 0x00000002, lo = 0xFFFFFFFA.
- div: a = 0xFFFFFFF9 (-7), b = 2, DIV_LAT = 10.
  - busy is high for exactly 10 cycles.
  - At commit: lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- divu: a = 7, b = 0 after hi/lo have been preset to 0x11111111 / 0x22222222 via wr_hi / wr_lo.
  - busy is high for 10 cycles.
  - hi and lo are unchanged at the end.
- Hazard checks:
  - Start mult, then at T+2 assert start (op = 2), wr_hi = 1 and wdata = 0xDEAD. Both are ignored; the original mult commits at T+6.
  - Assert reset at T+3 of a separate mult. After the edge busy = 0, hi = lo = 0, and no later commit occurs.
- Idle write: wr_hi = 1, wr_lo = 1, wdata = 0x12345678 with start = 0.
  - Next cycle: hi = lo = 0x12345678.
  - In the same-cycle start + wr_lo case, only the start is taken.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset; aborts any operation in flight
//   start  - launches op (0 mult, 1 multu, 2 div, 3 divu) when not busy
//   a, b   - operands (dividend, divisor for div/divu)
//   wr_hi  - mthi strobe; wr_lo - mtlo strobe; wdata - mthi/mtlo data
//   busy   - high while an operation is in flight
//   hi, lo - HI/LO registers (high product/remainder, low product/quotient)
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic                 r_pend_skip;
    logic [2*WIDTH-1:0]   w_prod_s, w_prod_u;
    logic signed [WIDTH-1:0] w_q_s, w_r_s;
    logic [WIDTH-1:0]     w_q_u, w_r_u, w_res_hi, w_res_lo;
    logic                 w_ovf, w_div0;

    assign w_prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_q_s    = $signed(a) / $signed(b);
    assign w_r_s    = $signed(a) % $signed(b);
    assign w_q_u    = a / b;
    assign w_r_u    = a % b;
    // most-negative / -1 cannot be represented; defined as lo = a, hi = 0
    assign w_ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    assign w_div0   = op[1] && (b == '0);

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_hi = op[1] ? (op[0] ? w_r_u : (w_ovf ? '0 : w_r_s))
                         : (op[0] ? w_prod_u[2*WIDTH-1:WIDTH] : w_prod_s[2*WIDTH-1:WIDTH]);
        w_res_lo = op[1] ? (op[0] ? w_q_u : (w_ovf ? a : w_q_s))
                         : (op[0] ? w_prod_u[WIDTH-1:0] : w_prod_s[WIDTH-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_pend_hi   <= '0;
            r_pend_lo   <= '0;
            r_pend_skip <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1) && !r_pend_skip) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (start) begin
            r_cnt       <= op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
            r_pend_hi   <= w_res_hi;
            r_pend_lo   <= w_res_lo;
            r_pend_skip <= w_div0;
        end else begin
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
        end
    end

    assign busy = (r_cnt != '0);
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
